// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment scan decoding: glyph codes, default dwell, digit index.
package seg7_pkg;

    localparam int STABLE_CYCLES_DEF = 4;

    typedef logic [1:0] digit_t;

    localparam logic [6:0] GLYPH_0 = 7'h7E;
    localparam logic [6:0] GLYPH_1 = 7'h30;
    localparam logic [6:0] GLYPH_2 = 7'h6D;
    localparam logic [6:0] GLYPH_3 = 7'h79;
    localparam logic [6:0] GLYPH_4 = 7'h33;
    localparam logic [6:0] GLYPH_5 = 7'h5B;
    localparam logic [6:0] GLYPH_6 = 7'h5F;
    localparam logic [6:0] GLYPH_7 = 7'h70;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h7B;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h1F;
    localparam logic [6:0] GLYPH_C = 7'h4E;
    localparam logic [6:0] GLYPH_D = 7'h3D;
    localparam logic [6:0] GLYPH_E = 7'h4F;
    localparam logic [6:0] GLYPH_F = 7'h47;

    // Element i holds the segment pattern of hex digit i.
    localparam logic [15:0][6:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    function automatic logic one_cold(input logic [3:0] an);
        return an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    endfunction

    function automatic digit_t cold_idx(input logic [3:0] an);
        case (an)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational glyph decoder: segment pattern to hex nibble, with a legality flag.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed 7-segment display bus.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        value_stb,
    output logic [3:0]  digit_err
);

    localparam logic [7:0] SAT = 8'(STABLE_CYCLES);

    logic [6:0]      r_seg, p_seg;
    logic [3:0]      r_an, p_an;
    logic [7:0]      dwell;
    logic [3:0]      captured, cap_base, cap_nxt, sel;
    logic [3:0][3:0] shadow;
    logic            done, done_nxt;
    logic            same, fire, legal;
    logic [3:0]      nib;
    digit_t          idx;

    seg7_to_hex u_hex (
        .seg    (r_seg),
        .nibble (nib),
        .legal  (legal)
    );

    always_comb begin
        same     = one_cold(r_an) && (r_an == p_an) && (r_seg == p_seg);
        fire     = same && (dwell == SAT - 8'd1);
        idx      = cold_idx(r_an);
        sel      = 4'b0001 << idx;
        // A pending frame completion empties the mask on this same edge.
        cap_base = done ? 4'h0 : captured;
        cap_nxt  = cap_base;
        if (fire) cap_nxt = legal ? (cap_base | sel) : (cap_base & ~sel);
        done_nxt = fire && legal && ((cap_base | sel) == 4'hF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg     <= 7'h00;
            r_an      <= 4'hF;
            p_seg     <= 7'h00;
            p_an      <= 4'hF;
            dwell     <= 8'd0;
            captured  <= 4'h0;
            shadow    <= '0;
            done      <= 1'b0;
            value     <= 16'h0000;
            value_stb <= 1'b0;
            digit_err <= 4'h0;
        end else begin
            r_seg     <= seg;
            r_an      <= an;
            p_seg     <= r_seg;
            p_an      <= r_an;
            dwell     <= !same ? 8'd0 : (dwell == SAT) ? dwell : dwell + 8'd1;
            captured  <= cap_nxt;
            done      <= done_nxt;
            value_stb <= done;
            if (done) value <= shadow;
            if (fire) begin
                if (legal) begin
                    shadow[idx]    <= nib;
                    digit_err[idx] <= 1'b0;
                end else begin
                    digit_err[idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed and randomized-scan bench for seg7_scan_decoder.
module tb_seg7_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h00;
    logic [3:0]  an = 4'hF;
    logic [15:0] value;
    logic        value_stb;
    logic [3:0]  digit_err;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .an        (an),
        .value     (value),
        .value_stb (value_stb),
        .digit_err (digit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] val;
        logic [3:0]  err;
        int          nstb;
        bit          lat;
    } vec_t;

    logic [6:0] gl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int          checks = 0, errors = 0;
    int          cyc = 0, stb_cnt = 0, last_stb_cyc = 0;
    logic        prev_stb = 1'b0;
    bit          sb_en = 1'b0;
    logic [15:0] sbq [$];
    vec_t        tbl [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Strobe monitor: counts pulses, rejects back-to-back pulses, and scoreboards in random mode.
    always @(negedge clk) begin
        if (value_stb) begin
            stb_cnt++;
            last_stb_cyc = cyc;
            chk("stb_not_back_to_back", int'(prev_stb), 0);
            if (sb_en) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_stb: got value %h expected no strobe", value);
                end else begin
                    chk("random_frame_value", int'(value), int'(sbq.pop_front()));
                end
            end
        end
        prev_stb = value_stb;
    end

    // Called at a negedge; holds the pair for n rising edges and returns at a negedge.
    task automatic present(input logic [3:0] a, input logic [6:0] s, input int n, output int n0);
        an  = a;
        seg = s;
        n0  = cyc + 1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n0, base;
        logic [3:0]      cap;
        logic [3:0][3:0] msh;
        logic [3:0]      a, pa;
        logic [6:0]      s, ps;
        int              d, g;

        tbl.push_back(vec_t'{4'b1110, 7'h7E, 8,  16'h0000, 4'h0, 0, 0});
        tbl.push_back(vec_t'{4'b1101, 7'h30, 8,  16'h0000, 4'h0, 0, 0});
        tbl.push_back(vec_t'{4'b1011, 7'h6D, 8,  16'h0000, 4'h0, 0, 0});
        tbl.push_back(vec_t'{4'b0111, 7'h79, 8,  16'h3210, 4'h0, 1, 1});
        tbl.push_back(vec_t'{4'b1011, 7'h00, 8,  16'h3210, 4'h4, 1, 0});
        tbl.push_back(vec_t'{4'b1110, 7'h7F, 8,  16'h3210, 4'h4, 1, 0});
        tbl.push_back(vec_t'{4'b1101, 7'h33, 8,  16'h3210, 4'h4, 1, 0});
        tbl.push_back(vec_t'{4'b0111, 7'h47, 8,  16'h3210, 4'h4, 1, 0});
        tbl.push_back(vec_t'{4'b1011, 7'h5B, 8,  16'hF548, 4'h0, 2, 1});
        tbl.push_back(vec_t'{4'b1100, 7'h7F, 10, 16'hF548, 4'h0, 2, 0});
        tbl.push_back(vec_t'{4'b0111, 7'h7F, 8,  16'hF548, 4'h0, 2, 0});
        tbl.push_back(vec_t'{4'b1011, 7'h7F, 8,  16'hF548, 4'h0, 2, 0});
        tbl.push_back(vec_t'{4'b1101, 7'h7F, 8,  16'hF548, 4'h0, 2, 0});
        tbl.push_back(vec_t'{4'b1110, 7'h7F, 8,  16'h8888, 4'h0, 3, 1});
        tbl.push_back(vec_t'{4'b1110, 7'h01, 8,  16'h8888, 4'h1, 3, 0});
        tbl.push_back(vec_t'{4'b1111, 7'h7E, 10, 16'h8888, 4'h1, 3, 0});
        tbl.push_back(vec_t'{4'b0000, 7'h7E, 10, 16'h8888, 4'h1, 3, 0});
        tbl.push_back(vec_t'{4'b1110, 7'h1F, 8,  16'h8888, 4'h0, 3, 0});
        tbl.push_back(vec_t'{4'b1101, 7'h77, 8,  16'h8888, 4'h0, 3, 0});
        tbl.push_back(vec_t'{4'b1011, 7'h4E, 8,  16'h8888, 4'h0, 3, 0});
        tbl.push_back(vec_t'{4'b0111, 7'h3D, 8,  16'hDCAB, 4'h0, 4, 1});

        repeat (2) @(negedge clk);
        chk("reset_value", int'(value), 0);
        chk("reset_stb", int'(value_stb), 0);
        chk("reset_err", int'(digit_err), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            present(tbl[i].an, tbl[i].seg, tbl[i].hold, n0);
            chk($sformatf("vec%0d_value", i), int'(value), int'(tbl[i].val));
            chk($sformatf("vec%0d_err", i), int'(digit_err), int'(tbl[i].err));
            chk($sformatf("vec%0d_nstb", i), stb_cnt, tbl[i].nstb);
            if (tbl[i].lat) chk($sformatf("vec%0d_latency", i), last_stb_cyc - n0, S + 2);
        end

        // Short dwell on digit 0 must not capture it.
        base = stb_cnt;
        present(4'b1110, 7'h7E, S - 1, n0);
        present(4'b1111, 7'h7E, 6, n0);
        chk("short_dwell_err", int'(digit_err), 0);
        present(4'b1101, 7'h30, 8, n0);
        present(4'b1011, 7'h6D, 8, n0);
        present(4'b0111, 7'h79, 8, n0);
        chk("short_dwell_no_stb", stb_cnt, base);
        present(4'b1110, 7'h7E, 8, n0);
        chk("short_dwell_then_full_stb", stb_cnt, base + 1);
        chk("short_dwell_then_full_value", int'(value), 16'h3210);

        // Reset in the middle of a frame discards captured digits.
        base = stb_cnt;
        present(4'b0111, 7'h00, 8, n0);
        present(4'b1110, 7'h7E, 8, n0);
        present(4'b1101, 7'h30, 8, n0);
        present(4'b1011, 7'h6D, 8, n0);
        chk("pre_reset_err", int'(digit_err), 4'h8);
        chk("pre_reset_no_stb", stb_cnt, base);
        rst_n = 1'b0;
        an    = 4'hF;
        #1;
        chk("midreset_value", int'(value), 0);
        chk("midreset_err", int'(digit_err), 0);
        chk("midreset_stb", int'(value_stb), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        present(4'b0111, 7'h79, 10, n0);
        chk("post_reset_single_no_stb", stb_cnt, base);
        chk("post_reset_value", int'(value), 0);
        present(4'b1110, 7'h7E, 8, n0);
        present(4'b1101, 7'h30, 8, n0);
        present(4'b1011, 7'h6D, 8, n0);
        chk("post_reset_frame_stb", stb_cnt, base + 1);
        chk("post_reset_frame_value", int'(value), 16'h3210);

        // Random scan order and glyphs against a reference model.
        sb_en = 1'b1;
        cap = 4'h0;
        msh = '0;
        pa  = 4'hF;
        ps  = 7'h00;
        for (int k = 0; k < 80; k++) begin
            do begin
                d = int'($urandom_range(0, 3));
                g = int'($urandom_range(0, 15));
                a = ~(4'b0001 << d);
                s = gl[g];
            end while (a == pa && s == ps);
            msh[d] = 4'(g);
            cap    = cap | (4'b0001 << d);
            if (cap == 4'hF) begin
                sbq.push_back(msh);
                cap = 4'h0;
            end
            present(a, s, int'($urandom_range(S + 1, S + 4)), n0);
            pa = a;
            ps = s;
            if ($urandom_range(0, 3) == 0) begin
                present(($urandom_range(0, 1) == 0) ? 4'hF : 4'b0101, 7'(gl[$urandom_range(0, 15)]),
                        int'($urandom_range(1, 6)), n0);
                pa = 4'hF;
            end
        end
        an = 4'hF;
        repeat (10) @(negedge clk);
        chk("random_all_frames_seen", sbq.size(), 0);
        sb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
